// File: rtl/ipv4_field_extract_pkg.sv
// Stream beat type shared by the IPv4 field extractor and its users.
package ipv4_field_extract_pkg;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              sop;
        logic              eop;
    } avln_st;
endpackage

// File: rtl/ipv4_field_extract.sv
// Walks Ethernet (optionally VLAN-tagged) framing to an IPv4 header and captures
// a parameterised set of header fields, with per-packet event counters.
module ipv4_field_extract
    import ipv4_field_extract_pkg::*;
#(
    parameter int N_FIELDS                = 2,
    parameter int FIELD_W                 = 16,
    parameter int FIELD_WORD [N_FIELDS]   = '{1, 2},
    parameter int FIELD_OFS  [N_FIELDS]   = '{0, 0},
    parameter int FIELD_SIZE [N_FIELDS]   = '{16, 8},
    parameter int MAX_VLAN_TAGS           = 2,
    parameter int CHECK_VERSION           = 1
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  avln_st                       in,
    output logic [N_FIELDS*FIELD_W-1:0]  fields,
    output logic                         fields_valid,
    output logic                         ipv4_start,
    output logic                         truncated,
    output logic [31:0]                  ipv4_count,
    output logic [31:0]                  trunc_count,
    output logic [31:0]                  nonip_count
);
    localparam int W = DATA_W;

    function automatic int max_field_word();
        int m = 0;
        for (int i = 0; i < N_FIELDS; i++)
            if (FIELD_WORD[i] > m) m = FIELD_WORD[i];
        return m;
    endfunction

    localparam int LAST_WORD = max_field_word();

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
    endfunction

    typedef enum logic [1:0] {IDLE, ETH, HDR, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  word_cnt, word_next;
    logic [1:0]  tag_cnt, tag_next;
    logic [3:0]  hdr_cnt, hdr_next;
    logic        ipv4_hit, fv_hit, trunc_hit, nonip_hit, cap_en;
    logic [15:0] ethertype;
    logic        is_vlan, eth_word, bad_version;
    logic [FIELD_W-1:0] cap_val [N_FIELDS];

    assign ethertype   = in.data[15:0];
    assign is_vlan     = ethertype inside {16'h8100, 16'h88A8, 16'h9100};
    assign eth_word    = (word_cnt == 3'd3 + 3'(tag_cnt));
    assign bad_version = (CHECK_VERSION != 0) && (in.data[W-1 -: 4] != 4'd4);

    // Each field slice is fixed at elaboration, so extraction is pure wiring.
    for (genvar g = 0; g < N_FIELDS; g++) begin : g_cap
        assign cap_val[g] = FIELD_W'(in.data[W-1-FIELD_OFS[g] -: FIELD_SIZE[g]]);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            tag_cnt  <= '0;
            hdr_cnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            word_cnt <= word_next;
            tag_cnt  <= tag_next;
            hdr_cnt  <= hdr_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_next = state;
        word_next  = word_cnt;
        tag_next   = tag_cnt;
        hdr_next   = hdr_cnt;
        ipv4_hit   = 1'b0;
        fv_hit     = 1'b0;
        trunc_hit  = 1'b0;
        nonip_hit  = 1'b0;
        cap_en     = 1'b0;
        if (in.valid) begin
            if (in.sop) begin
                word_next = 3'd1;
                tag_next  = '0;
                hdr_next  = '0;
                trunc_hit = (state == HDR);
                if (in.eop) begin
                    nonip_hit  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = ETH;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    ETH: begin
                        if (!eth_word) begin
                            word_next = word_cnt + 3'd1;
                            if (in.eop) begin
                                nonip_hit  = 1'b1;
                                state_next = IDLE;
                            end
                        end else if (ethertype == 16'h0800) begin
                            ipv4_hit   = 1'b1;
                            hdr_next   = '0;
                            trunc_hit  = in.eop;
                            state_next = in.eop ? IDLE : HDR;
                        end else if (is_vlan && int'(tag_cnt) < MAX_VLAN_TAGS && !in.eop) begin
                            tag_next  = tag_cnt + 2'd1;
                            word_next = word_cnt + 3'd1;
                        end else begin
                            nonip_hit  = 1'b1;
                            state_next = in.eop ? IDLE : DONE;
                        end
                    end
                    HDR: begin
                        if (hdr_cnt == 4'd0 && bad_version) begin
                            nonip_hit  = 1'b1;
                            state_next = in.eop ? IDLE : DONE;
                        end else begin
                            cap_en = 1'b1;
                            if (hdr_cnt == 4'(LAST_WORD)) begin
                                fv_hit     = 1'b1;
                                state_next = in.eop ? IDLE : DONE;
                            end else if (in.eop) begin
                                trunc_hit  = 1'b1;
                                state_next = IDLE;
                            end else begin
                                hdr_next = hdr_cnt + 4'd1;
                            end
                        end
                    end
                    DONE: if (in.eop) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            fields       <= '0;
            fields_valid <= 1'b0;
            ipv4_start   <= 1'b0;
            truncated    <= 1'b0;
            ipv4_count   <= '0;
            trunc_count  <= '0;
            nonip_count  <= '0;
        end else begin
            fields_valid <= fv_hit;
            ipv4_start   <= ipv4_hit;
            truncated    <= trunc_hit;
            ipv4_count   <= sat_inc(ipv4_count, ipv4_hit);
            trunc_count  <= sat_inc(trunc_count, trunc_hit);
            nonip_count  <= sat_inc(nonip_count, nonip_hit);
            for (int i = 0; i < N_FIELDS; i++)
                if (cap_en && int'(hdr_cnt) == FIELD_WORD[i])
                    fields[i*FIELD_W +: FIELD_W] <= cap_val[i];
        end
    end
endmodule
